tc_pl_spi_arb: RTL and testbench
================================

// Module: tc_pl_spi_arb
// PURPOSE
//  Parametrised successor to the cap/bus output steering in Tc_PL. Routes NSRC SPI master groups
//  (SCK/CSN/SDI per device plus static control lines such as OPA gain bits) onto NDEV shared devices.
//  Handover to a new owner is glitch-free: the old owner's frame is drained, then a guard gap with all
//  CSN deasserted, then the switch. Sits between Tc_PL_cap / Tc_PL_bus / Tc_PL_chips and the board pins.
// PARAMETERS
//  NSRC     2   number of master groups (>=2); SW = $clog2(NSRC) localparam
//  NDEV     2   number of SPI devices sharing the pins (e.g. FDA0, DAC0)
//  NGPO     4   static control lines per group (e.g. OPA0_10X1/10X2/OPX1/OPX2)
//  GUARD    8   idle cycles with all CSN high between owners (>=1)
//  TMO      1024 max DRAIN cycles before forced handover
//  CPOL     0   idle SCK level driven outside ownership
//  RST_OWN  0   owner after reset
//  GPO_RST  0   dev_gpo value after reset [NGPO-1:0]
// PORTS
//  clk125    in   1             system clock
//  rst       in   1             synchronous, active-high reset
//  sel       in   SW            requested owner (e.g. Gc_cap_mode)
//  src_sck   in   NSRC*NDEV     group s, device d at bit s*NDEV+d
//  src_csn   in   NSRC*NDEV     same packing, active-low
//  src_sdi   in   NSRC*NDEV     same packing
//  src_gpo   in   NSRC*NGPO     group s at bits [s*NGPO +: NGPO]
//  dev_sck   out  NDEV          registered to pins
//  dev_csn   out  NDEV          registered to pins
//  dev_sdi   out  NDEV          registered to pins
//  dev_gpo   out  NGPO          registered to pins
//  owner     out  SW            current owner
//  switching out  1             high in DRAIN or GUARD
//  drain_tmo out  1             1-cycle pulse on forced handover
//  sel_err   out  1             high while sel >= NSRC
// BEHAVIOUR
//  Reset: state OWN, owner=RST_OWN, dev_csn=all 1, dev_sck=all CPOL, dev_sdi=0, dev_gpo=GPO_RST,
//   switching=0, drain_tmo=0, sel_err=0, counters cleared. Reset mid-transfer aborts immediately.
//  All dev_* outputs registered: 1-cycle latency from src_* of owner.
//  OWN: forward owner's group. If sel valid and sel!=owner -> DRAIN (same edge, count=0).
//  DRAIN: keep forwarding old owner. When all NDEV of old owner's src_csn are 1 in a cycle -> GUARD.
//   count reaches TMO-1 first -> GUARD with drain_tmo pulse. sel back to owner -> OWN, no gap.
//  GUARD: dev_csn=all 1, dev_sck=CPOL, dev_sdi=0, dev_gpo held. After GUARD cycles, sample sel:
//   valid -> owner<=sel, OWN (may equal old owner); invalid -> owner unchanged, OWN.
//  sel >= NSRC: ignored for switching, sel_err=1 (registered) until a valid sel.
//  dev_gpo updates only in OWN/DRAIN; new owner's gpo appears first cycle after GUARD.
//  Non-owner inputs never reach pins. No combinational input-to-output path.
// CONFIGURATION
//  TC_SPI_ARB_SDO_EN defined: adds in dev_sdo[NDEV], out src_sdo[NSRC*NDEV]; src_sdo of owner =
//   dev_sdo registered (1 cycle), all other groups 0; during GUARD all src_sdo 0.
//  Undefined: ports absent, no read-back path (write-only devices).
// TESTING
//  1 Reset, NSRC=2: dev_csn=2'b11, dev_sck=0, dev_gpo=0, owner=0, switching=0.
//  2 owner 0 toggling src_sck[0] -> dev_sck[0] follows 1 cycle later; group1 toggles never visible.
//  3 sel 0->1 while group0 CSN low for 20 cycles: switching=1, group0 forwarded 20 cycles, then
//    exactly 8 cycles dev_csn=11, then owner=1 and group1 lines appear.
//  4 group0 CSN stuck low, sel->1: drain_tmo pulses at DRAIN cycle 1024, GUARD 8, owner=1.
//  5 sel 0->1->0 during DRAIN: returns to OWN owner=0, dev_csn never forced high; NSRC=3, sel=3 -> sel_err=1.
//  6 SDO_EN: owner=1, dev_sdo[0]=1 -> src_sdo[2]=1 next cycle, src_sdo[0]=0; reset mid-frame -> csn=all 1.

Source files
------------

// File: rtl/tc_pl_spi_arb_if.sv
// Bus bundle for tc_pl_spi_arb: NSRC master groups in, NDEV shared device pins out.
// TC_SPI_ARB_SDO_EN adds the dev_sdo -> src_sdo read-back lines.
interface tc_pl_spi_arb_if #(
  parameter int NSRC = 2,
  parameter int NDEV = 2,
  parameter int NGPO = 4
);
  localparam int SW = $clog2(NSRC);

  logic [SW-1:0]        sel;
  logic [NSRC*NDEV-1:0] src_sck;
  logic [NSRC*NDEV-1:0] src_csn;
  logic [NSRC*NDEV-1:0] src_sdi;
  logic [NSRC*NGPO-1:0] src_gpo;
  logic [NDEV-1:0]      dev_sck;
  logic [NDEV-1:0]      dev_csn;
  logic [NDEV-1:0]      dev_sdi;
  logic [NGPO-1:0]      dev_gpo;
  logic [SW-1:0]        owner;
  logic                 switching;
  logic                 drain_tmo;
  logic                 sel_err;
`ifdef TC_SPI_ARB_SDO_EN
  logic [NDEV-1:0]      dev_sdo;
  logic [NSRC*NDEV-1:0] src_sdo;
`endif

  modport slave (
`ifdef TC_SPI_ARB_SDO_EN
    input  dev_sdo,
    output src_sdo,
`endif
    input  sel, src_sck, src_csn, src_sdi, src_gpo,
    output dev_sck, dev_csn, dev_sdi, dev_gpo, owner, switching, drain_tmo, sel_err
  );

  modport master (
`ifdef TC_SPI_ARB_SDO_EN
    output dev_sdo,
    input  src_sdo,
`endif
    output sel, src_sck, src_csn, src_sdi, src_gpo,
    input  dev_sck, dev_csn, dev_sdi, dev_gpo, owner, switching, drain_tmo, sel_err
  );
endinterface

// File: rtl/tc_pl_spi_arb.sv
// Glitch-free SPI pin arbiter: drains the old owner's frame, idles all CSN for GUARD cycles, then switches.
// Optional read-back path enabled by defining TC_SPI_ARB_SDO_EN.
module tc_pl_spi_arb #(
  parameter int              NSRC    = 2,
  parameter int              NDEV    = 2,
  parameter int              NGPO    = 4,
  parameter int              GUARD   = 8,
  parameter int              TMO     = 1024,
  parameter int              CPOL    = 0,
  parameter int              RST_OWN = 0,
  parameter logic [NGPO-1:0] GPO_RST = '0
) (
  input  logic            clk125,
  input  logic            rst,
  tc_pl_spi_arb_if.slave  bus
);
  localparam int              SW       = $clog2(NSRC);
  localparam int              CMAX     = (TMO > GUARD) ? TMO : GUARD;
  localparam int              CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0]   GRD_LAST = CW'(GUARD - 1);
  localparam logic [SW:0]     NSRC_W   = (SW + 1)'(NSRC);
  localparam logic [NDEV-1:0] SCK_IDLE = (CPOL != 0) ? '1 : '0;
  localparam logic [SW-1:0]   OWN_RST  = SW'(RST_OWN);

  typedef enum logic [1:0] {S_OWN, S_DRAIN, S_GUARD} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NDEV-1:0] sck_q, sck_d, csn_q, csn_d, sdi_q, sdi_d;
  logic [NGPO-1:0] gpo_q, gpo_d;
  logic            tmo_q, tmo_d, serr_q, serr_d;
  logic            sel_ok;
  logic [NDEV-1:0] own_sck, own_csn, own_sdi;
  logic [NGPO-1:0] own_gpo;
`ifdef TC_SPI_ARB_SDO_EN
  logic [NSRC*NDEV-1:0] sdo_q, sdo_d;
`endif

  assign sel_ok = {1'b0, bus.sel} < NSRC_W;

  // Only the current owner's group is ever selected onto the pins.
  always_comb begin
    own_sck = '0;
    own_csn = '1;
    own_sdi = '0;
    own_gpo = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (owner_q == SW'(s)) begin
        own_sck = bus.src_sck[s*NDEV +: NDEV];
        own_csn = bus.src_csn[s*NDEV +: NDEV];
        own_sdi = bus.src_sdi[s*NDEV +: NDEV];
        own_gpo = bus.src_gpo[s*NGPO +: NGPO];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    serr_d  = !sel_ok;
    case (state_q)
      S_OWN: begin
        if (sel_ok && bus.sel != owner_q) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (sel_ok && bus.sel == owner_q) begin
          state_d = S_OWN;
        end else if (&own_csn) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == GRD_LAST) begin
          state_d = S_OWN;
          if (sel_ok) owner_d = bus.sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_OWN;
    endcase
  end

  // GUARD forces idle pins and freezes gpo; otherwise the owner is forwarded with one cycle latency.
  always_comb begin
    sck_d = own_sck;
    csn_d = own_csn;
    sdi_d = own_sdi;
    gpo_d = own_gpo;
    if (state_q == S_GUARD) begin
      sck_d = SCK_IDLE;
      csn_d = '1;
      sdi_d = '0;
      gpo_d = gpo_q;
    end
  end

`ifdef TC_SPI_ARB_SDO_EN
  always_comb begin
    sdo_d = '0;
    if (state_q != S_GUARD) begin
      for (int s = 0; s < NSRC; s++)
        if (owner_q == SW'(s)) sdo_d[s*NDEV +: NDEV] = bus.dev_sdo;
    end
  end
`endif

  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q <= S_OWN;
      owner_q <= OWN_RST;
      cnt_q   <= '0;
      sck_q   <= SCK_IDLE;
      csn_q   <= '1;
      sdi_q   <= '0;
      gpo_q   <= GPO_RST;
      tmo_q   <= 1'b0;
      serr_q  <= 1'b0;
`ifdef TC_SPI_ARB_SDO_EN
      sdo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
      sdi_q   <= sdi_d;
      gpo_q   <= gpo_d;
      tmo_q   <= tmo_d;
      serr_q  <= serr_d;
`ifdef TC_SPI_ARB_SDO_EN
      sdo_q   <= sdo_d;
`endif
    end
  end

  assign bus.dev_sck   = sck_q;
  assign bus.dev_csn   = csn_q;
  assign bus.dev_sdi   = sdi_q;
  assign bus.dev_gpo   = gpo_q;
  assign bus.owner     = owner_q;
  assign bus.switching = (state_q != S_OWN);
  assign bus.drain_tmo = tmo_q;
  assign bus.sel_err   = serr_q;
`ifdef TC_SPI_ARB_SDO_EN
  assign bus.src_sdo   = sdo_q;
`endif
endmodule

// File: tb/tb_tc_pl_spi_arb.sv
// Scoreboard bench for tc_pl_spi_arb: a per-cycle reference model queues expected pins, plus directed timing checks.
module tb_tc_pl_spi_arb;
  localparam int TMO = 1024;
  localparam int GRD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  tc_pl_spi_arb_if #(.NSRC(2), .NDEV(2), .NGPO(4)) bus ();
  tc_pl_spi_arb_if #(.NSRC(3), .NDEV(2), .NGPO(4)) bus3 ();

  tc_pl_spi_arb #(.NSRC(2), .NDEV(2), .NGPO(4), .GUARD(GRD), .TMO(TMO))
    u_dut (.clk125(clk), .rst(rst), .bus(bus.slave));
  tc_pl_spi_arb #(.NSRC(3), .NDEV(2), .NGPO(4), .GUARD(GRD), .TMO(TMO))
    u_dut3 (.clk125(clk), .rst(rst), .bus(bus3.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // reference model state: st 0=OWN 1=DRAIN 2=GUARD
  int         m_st, m_own, m_cnt;
  logic [3:0] m_gpo;
  logic [13:0] sb[$];

  task automatic model_reset();
    m_st = 0; m_own = 0; m_cnt = 0; m_gpo = 4'h0;
  endtask

  task automatic cyc();
    logic [1:0]  osck, ocsn, osdi, esck, ecsn, esdi;
    logic [3:0]  ogpo, egpo;
    logic [13:0] exp, got;
    int nst, nown, ncnt;
    bit ntmo;
    osck = (m_own == 1) ? bus.src_sck[3:2] : bus.src_sck[1:0];
    ocsn = (m_own == 1) ? bus.src_csn[3:2] : bus.src_csn[1:0];
    osdi = (m_own == 1) ? bus.src_sdi[3:2] : bus.src_sdi[1:0];
    ogpo = (m_own == 1) ? bus.src_gpo[7:4] : bus.src_gpo[3:0];
    if (m_st == 2) begin
      esck = 2'b00; ecsn = 2'b11; esdi = 2'b00; egpo = m_gpo;
    end else begin
      esck = osck; ecsn = ocsn; esdi = osdi; egpo = ogpo;
    end
    nst = m_st; nown = m_own; ncnt = m_cnt; ntmo = 1'b0;
    case (m_st)
      0: if (int'(bus.sel) != m_own) begin nst = 1; ncnt = 0; end
      1: begin
        if (int'(bus.sel) == m_own) nst = 0;
        else if (ocsn == 2'b11) begin nst = 2; ncnt = 0; end
        else if (m_cnt == TMO - 1) begin nst = 2; ncnt = 0; ntmo = 1'b1; end
        else ncnt = m_cnt + 1;
      end
      default: begin
        if (m_cnt == GRD - 1) begin nst = 0; nown = int'(bus.sel); end
        else ncnt = m_cnt + 1;
      end
    endcase
    sb.push_back({esck, ecsn, esdi, egpo, nown[0], (nst != 0), ntmo, 1'b0});
    m_st = nst; m_own = nown; m_cnt = ncnt; m_gpo = egpo;
    @(posedge clk); #1;
    exp = sb.pop_front();
    got = {bus.dev_sck, bus.dev_csn, bus.dev_sdi, bus.dev_gpo, bus.owner,
           bus.switching, bus.drain_tmo, bus.sel_err};
    chk("cyc", 32'(got), 32'(exp));
  endtask

  initial begin
    int n, m;
    bit seen;
    bus.sel = 1'b0; bus.src_sck = 4'h0; bus.src_csn = 4'hF; bus.src_sdi = 4'h0;
    bus.src_gpo = 8'hA5;
    bus3.sel = 2'd0; bus3.src_sck = 6'h0; bus3.src_csn = 6'h3F; bus3.src_sdi = 6'h0;
    bus3.src_gpo = 12'h0;
`ifdef TC_SPI_ARB_SDO_EN
    bus.dev_sdo = 2'b00; bus3.dev_sdo = 2'b00;
`endif
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_csn", 32'(bus.dev_csn), 32'h3);
    chk("rst_sck", 32'(bus.dev_sck), 32'h0);
    chk("rst_gpo", 32'(bus.dev_gpo), 32'h0);
    chk("rst_own", 32'(bus.owner), 32'h0);
    chk("rst_sw",  32'(bus.switching), 32'h0);
    chk("rst_tmo", 32'(bus.drain_tmo), 32'h0);
    rst = 1'b0;
    model_reset();

    // owner 0 forwarded, group 1 activity must never show
    for (int i = 0; i < 16; i++) begin
      bus.src_sck = 4'(i); bus.src_sdi = 4'($urandom); bus.src_csn = {2'($urandom), 2'b00};
      bus.src_gpo = 8'($urandom);
      cyc();
    end
    bus.src_sck = 4'b1100;
    cyc();
    chk("sck_iso", 32'(bus.dev_sck), 32'h0);
    bus.src_sck = 4'b0001;
    cyc();
    chk("sck_fol", 32'(bus.dev_sck), 32'h1);

    // 20-cycle drain, then exactly GRD switching cycles
    bus.sel = 1'b1; bus.src_csn = 4'b0100; bus.src_gpo = 8'h3C;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.switching && bus.dev_csn == 2'b00) n++;
    end
    chk("drain20", 32'(n), 32'd20);
    bus.src_csn = 4'b0111;
    n = 0; m = 0;
    for (int i = 0; i < 40 && !(bus.owner == 1'b1 && !bus.switching); i++) begin
      cyc();
      if (bus.switching) n++;
      if (bus.switching && bus.dev_csn == 2'b11) m++;
    end
    chk("guard_len", 32'(n), 32'(GRD));
    chk("guard_csn", 32'(m), 32'(GRD));
    chk("own1", 32'(bus.owner), 32'h1);
    cyc();
    chk("g1_csn", 32'(bus.dev_csn), 32'h1);
    chk("g1_gpo", 32'(bus.dev_gpo), 32'h3);

    // forced handover after TMO drain cycles
    bus.sel = 1'b0; bus.src_csn = 4'b0011;
    n = 0; seen = 1'b0;
    for (int i = 0; i < TMO + 100 && !seen; i++) begin
      cyc();
      if (bus.drain_tmo) seen = 1'b1;
      else if (bus.switching) n++;
    end
    chk("tmo_seen", 32'(seen), 32'h1);
    chk("tmo_pos", 32'(n), 32'(TMO));
    cyc();
    chk("tmo_pulse", 32'(bus.drain_tmo), 32'h0);
    for (int i = 0; i < 40 && bus.switching; i++) cyc();
    chk("own0", 32'(bus.owner), 32'h0);

    // sel bounces back during drain: no gap
    bus.src_csn = 4'b1100;
    cyc();
    bus.sel = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(); if (bus.dev_csn == 2'b11) seen = 1'b1; end
    bus.sel = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(); if (bus.dev_csn == 2'b11) seen = 1'b1; end
    chk("no_gap", 32'(seen), 32'h0);
    chk("back_sw", 32'(bus.switching), 32'h0);
    chk("back_own", 32'(bus.owner), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.sel = 1'($urandom);
      bus.src_sck = 4'($urandom); bus.src_sdi = 4'($urandom); bus.src_gpo = 8'($urandom);
      bus.src_csn = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      cyc();
    end

    // NSRC=3: out-of-range sel flags an error and never starts a switch
    bus3.sel = 2'd3;
    @(posedge clk); #1;
    chk("serr_set", 32'(bus3.sel_err), 32'h1);
    chk("serr_nosw", 32'(bus3.switching), 32'h0);
    bus3.sel = 2'd2;
    @(posedge clk); #1;
    chk("serr_clr", 32'(bus3.sel_err), 32'h0);
    chk("sw3", 32'(bus3.switching), 32'h1);

`ifdef TC_SPI_ARB_SDO_EN
    bus.sel = 1'b1; bus.src_csn = 4'hF;
    for (int i = 0; i < 40 && !(bus.owner == 1'b1 && !bus.switching); i++) cyc();
    bus.dev_sdo = 2'b01;
    cyc();
    chk("sdo_own", 32'(bus.src_sdo), 32'h4);
    bus.dev_sdo = 2'b00;
`endif

    // reset mid-frame releases every CSN at once
    bus.sel = 1'b0; bus.src_csn = 4'h0;
    repeat (3) cyc();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstm_csn", 32'(bus.dev_csn), 32'h3);
    chk("rstm_own", 32'(bus.owner), 32'h0);
    chk("rstm_sw", 32'(bus.switching), 32'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
